// File: rtl/regfile_writeback_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_if
//   Bundles the result producers, the register-file write port and the two
//   forwarding lookup ports of the write-back controller.
//
//   master : the surrounding pipeline (drives ALU/load results and lookups)
//   slave  : the write-back controller
//
//   alu_valid/alu_rd/alu_data     ALU result, always accepted
//   ld_valid/ld_ready/ld_rd/ld_data  load result with back-pressure
//   reg_write/write_reg/write_data   registered register-file write port
//   fwd_rs1/2 -> fwd_hit1/2, fwd_data1/2  combinational forwarding lookups
// -----------------------------------------------------------------------------
interface regfile_writeback_if #(
    parameter int WIDTH = 32
);
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;

    logic             ld_valid;
    logic             ld_ready;
    logic [4:0]       ld_rd;
    logic [WIDTH-1:0] ld_data;

    logic             reg_write;
    logic [4:0]       write_reg;
    logic [WIDTH-1:0] write_data;

    logic [4:0]       fwd_rs1;
    logic [4:0]       fwd_rs2;
    logic             fwd_hit1;
    logic             fwd_hit2;
    logic [WIDTH-1:0] fwd_data1;
    logic [WIDTH-1:0] fwd_data2;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  reg_write, write_reg, write_data,
        output fwd_rs1, fwd_rs2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output reg_write, write_reg, write_data,
        input  fwd_rs1, fwd_rs2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//   Write-side controller for the 32 x WIDTH register file. Owns the single
//   write port and merges a never-stalling ALU result path with a
//   back-pressured load path. Loads wait in a DEPTH-entry FIFO and drain into
//   cycles the ALU leaves idle. A younger ALU write to the same register kills
//   queued loads so they never overwrite it. Two forwarding lookups expose the
//   youngest queued or just-written value of a register.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (flushes the load FIFO)
//     bus    regfile_writeback_if.slave (producers, write port, forwarding)
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH = 4,   // load FIFO entries, power of two, >= 2
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_writeback_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic             hit;
        logic [WIDTH-1:0] data;
    } fwd_t;

    // FIFO state: live bits and occupancy are reset, payload is not.
    logic [DEPTH-1:0] live_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [AW:0]      count_q;

    // Output stage feeding the register file.
    logic             reg_write_q;
    logic [4:0]       write_reg_q;
    logic [WIDTH-1:0] write_data_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic alu_kill;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    // A full FIFO refuses a push even when it pops in the same cycle.
    assign push     = bus.ld_valid && !full;
    // The ALU owns the write port whenever it is valid.
    assign pop      = !bus.alu_valid && !empty;
    // A non-x0 ALU write supersedes every queued load to the same register.
    assign alu_kill = bus.alu_valid && (bus.alu_rd != 5'd0);

    assign bus.ld_ready   = !full;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block or statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Live bits: cleared by a matching ALU write or by popping, set on push.
    // The push slot differs from the pop slot whenever both happen, and kill
    // never coincides with pop, so the later assignments cannot mask a kill
    // that matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_kill && (rd_q[i] == bus.alu_rd)) live_q[i] <= 1'b0;
            end
            if (pop)  live_q[head_q] <= 1'b0;
            // The same-cycle ALU result is younger than the load being pushed.
            if (push) live_q[tail_q] <= !(alu_kill && (bus.ld_rd == bus.alu_rd));
        end
    end

    // NOTE: payload storage has no reset; the live bits and occupancy counter
    // alone decide whether an entry means anything.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= bus.ld_rd;
            data_q[tail_q] <= bus.ld_data;
        end
    end

    // Write-port arbitration: ALU first, then FIFO head, else idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else if (bus.alu_valid) begin
            reg_write_q  <= (bus.alu_rd != 5'd0);
            write_reg_q  <= bus.alu_rd;
            write_data_q <= bus.alu_data;
        end else if (pop) begin
            if (live_q[head_q]) begin
                reg_write_q  <= (rd_q[head_q] != 5'd0);
                write_reg_q  <= rd_q[head_q];
                write_data_q <= data_q[head_q];
            end else begin
                // Killed entry: the slot is consumed but writes nothing.
                reg_write_q  <= 1'b0;
                write_reg_q  <= '0;
                write_data_q <= '0;
            end
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    // Youngest pending value of rs. The output stage is the oldest pending
    // write, then FIFO slots are scanned head to tail so the youngest match
    // overrides. Only occupied slots can be live.
    function automatic fwd_t lookup(input logic [4:0] rs);
        fwd_t          r;
        logic [AW-1:0] idx;
        r = '0;
        if (rs != 5'd0) begin
            if (reg_write_q && (write_reg_q == rs)) begin
                r.hit  = 1'b1;
                r.data = write_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + AW'(k);
                if (live_q[idx] && (rd_q[idx] == rs)) begin
                    r.hit  = 1'b1;
                    r.data = data_q[idx];
                end
            end
        end
        return r;
    endfunction

    fwd_t fwd1;
    fwd_t fwd2;

    // NOTE: every always_comb output is assigned on every path (here by the
    // function's own default) so no latch is inferred.
    always_comb begin
        fwd1 = lookup(bus.fwd_rs1);
        fwd2 = lookup(bus.fwd_rs2);
    end

    assign bus.fwd_hit1  = fwd1.hit;
    assign bus.fwd_data1 = fwd1.data;
    assign bus.fwd_hit2  = fwd2.hit;
    assign bus.fwd_data2 = fwd2.data;

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//   Directed bench for regfile_writeback (DEPTH=4, WIDTH=32): reset, ALU path,
//   FIFO fill/drain under ALU stall, kill, x0, forwarding, reset mid-stream.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    regfile_writeback_if #(.WIDTH(32)) bus ();

    regfile_writeback #(.DEPTH(4), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [4:0] rd,
                               input logic [31:0] d);
        check({tag, "_we"},   32'(bus.reg_write), 32'(we));
        check({tag, "_reg"},  32'(bus.write_reg), 32'(rd));
        check({tag, "_data"}, bus.write_data, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        bus.fwd_rs1 = 5'd3;
        bus.fwd_rs2 = 5'd0;

        // ---------------- reset state ----------------
        #12;
        check_write("reset", 1'b0, 5'd0, 32'h0);
        check("reset_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("reset_fwd_hit1", 32'(bus.fwd_hit1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- ALU path ----------------
        set_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        check_write("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("alu_idle_we", 32'(bus.reg_write), 32'd0);

        // ---------------- fill under ALU stall ----------------
        for (int c = 0; c < 5; c++) begin
            set_alu(1'b1, 5'(c + 1), 32'h1000 + 32'(c));
            set_ld(1'b1, 5'(10 + c), 32'h10A + 32'(c));
            #1;
            check($sformatf("fill_ready_%0d", c), 32'(bus.ld_ready), (c < 4) ? 32'd1 : 32'd0);
            tick();
            check_write($sformatf("fill_alu_%0d", c), 1'b1, 5'(c + 1), 32'h1000 + 32'(c));
        end

        // ---------------- drain: 10..14 in order ----------------
        set_alu(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_write($sformatf("drain_%0d", i), 1'b1, 5'(10 + i), 32'h10A + 32'(i));
            if (i == 0) check("drain_ready_after_pop", 32'(bus.ld_ready), 32'd1);
            if (i == 1) set_ld(1'b0, 5'd0, 32'h0);
        end
        tick();
        check("drain_idle_we", 32'(bus.reg_write), 32'd0);

        // ---------------- kill: load queued, then ALU ----------------
        set_ld(1'b1, 5'd7, 32'h11);
        tick();
        set_ld(1'b0, 5'd0, 32'h0);
        set_alu(1'b1, 5'd7, 32'h22);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        check_write("kill_alu", 1'b1, 5'd7, 32'h22);
        tick();
        check_write("kill_pop", 1'b0, 5'd0, 32'h0);
        tick();
        check("kill_idle_we", 32'(bus.reg_write), 32'd0);

        // ---------------- kill: same-cycle load and ALU ----------------
        set_ld(1'b1, 5'd7, 32'h11);
        set_alu(1'b1, 5'd7, 32'h22);
        tick();
        set_ld(1'b0, 5'd0, 32'h0);
        set_alu(1'b0, 5'd0, 32'h0);
        check_write("kill2_alu", 1'b1, 5'd7, 32'h22);
        tick();
        check_write("kill2_pop", 1'b0, 5'd0, 32'h0);

        // ---------------- x0 ----------------
        set_alu(1'b1, 5'd0, 32'h5);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        check("x0_alu_we", 32'(bus.reg_write), 32'd0);
        set_ld(1'b1, 5'd0, 32'h33);
        tick();
        set_ld(1'b0, 5'd0, 32'h0);
        bus.fwd_rs1 = 5'd0;
        #1;
        check("x0_fwd_hit1", 32'(bus.fwd_hit1), 32'd0);
        check("x0_fwd_data1", bus.fwd_data1, 32'h0);
        tick();
        check("x0_pop_we", 32'(bus.reg_write), 32'd0);
        tick();
        check("x0_idle_we", 32'(bus.reg_write), 32'd0);

        // ---------------- forwarding ----------------
        set_alu(1'b1, 5'd20, 32'h55);
        set_ld(1'b1, 5'd3, 32'hA);
        tick();
        set_alu(1'b1, 5'd21, 32'h66);
        set_ld(1'b1, 5'd3, 32'hB);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        bus.fwd_rs1 = 5'd3;
        bus.fwd_rs2 = 5'd21;
        #1;
        check("fwd_q_hit1", 32'(bus.fwd_hit1), 32'd1);
        check("fwd_q_data1", bus.fwd_data1, 32'hB);
        check("fwd_out_hit2", 32'(bus.fwd_hit2), 32'd1);
        check("fwd_out_data2", bus.fwd_data2, 32'h66);
        tick();
        check_write("fwd_pop_a", 1'b1, 5'd3, 32'hA);
        check("fwd_pa_data1", bus.fwd_data1, 32'hB);
        check("fwd_pa_hit2", 32'(bus.fwd_hit2), 32'd0);
        tick();
        check_write("fwd_pop_b", 1'b1, 5'd3, 32'hB);
        check("fwd_pb_hit1", 32'(bus.fwd_hit1), 32'd1);
        check("fwd_pb_data1", bus.fwd_data1, 32'hB);
        tick();
        check("fwd_idle_hit1", 32'(bus.fwd_hit1), 32'd0);
        check("fwd_idle_data1", bus.fwd_data1, 32'h0);
        set_alu(1'b1, 5'd3, 32'hC);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        check("fwd_stage_hit1", 32'(bus.fwd_hit1), 32'd1);
        check("fwd_stage_data1", bus.fwd_data1, 32'hC);

        // ---------------- reset mid-stream with 3 loads queued ----------------
        set_alu(1'b1, 5'd1, 32'h77);
        for (int c = 0; c < 3; c++) begin
            set_ld(1'b1, 5'(8 + c), 32'h80 + 32'(c));
            tick();
        end
        bus.fwd_rs1 = 5'd9;
        #1;
        check("mid_pre_hit1", 32'(bus.fwd_hit1), 32'd1);
        check("mid_pre_we", 32'(bus.reg_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_write("mid_reset", 1'b0, 5'd0, 32'h0);
        check("mid_reset_ready", 32'(bus.ld_ready), 32'd1);
        check("mid_reset_hit1", 32'(bus.fwd_hit1), 32'd0);
        check("mid_reset_data1", bus.fwd_data1, 32'h0);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_reset_we_%0d", i), 32'(bus.reg_write), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
